// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with a post-reset clear sequencer, optional
// write-to-read bypass and a per-register busy scoreboard for RAW hazard detection.
module regfile_scoreboard #(
    parameter int DATA_W         = 32,
    parameter int NUM_REGS       = 32,
    parameter int NUM_READ       = 2,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int ADDR_W        = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_READ*ADDR_W-1:0]   read_addr,
    output logic [NUM_READ*DATA_W-1:0]   read_data,
    output logic [NUM_READ-1:0]          read_busy,
    input  logic                         write_en,
    input  logic [ADDR_W-1:0]            write_addr,
    input  logic [DATA_W-1:0]            write_data,
    input  logic                         reserve_en,
    input  logic [ADDR_W-1:0]            reserve_addr,
    output logic                         ready
);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_clr_idx;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;
    logic                w_run;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_CLEAR;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_CLEAR: if (CLEAR_ON_RESET == 0 || r_clr_idx == ADDR_W'(NUM_REGS - 1))
                         w_state_next = S_RUN;
            default: w_state_next = r_state;
        endcase
    end

    always_comb begin
        w_run = (r_state == S_RUN);
        ready = w_run;
    end

    // Index starts at 1: register 0 is hardwired and never stored.
    always_ff @(posedge clk) begin
        if (rst)                    r_clr_idx <= ADDR_W'(1);
        else if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLEAR && CLEAR_ON_RESET != 0)
                r_regs[r_clr_idx] <= '0;
            else if (w_run && write_en && write_addr != '0)
                r_regs[write_addr] <= write_data;
        end
    end

    // Reserve is applied after the write clear so a same-cycle reserve wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else if (w_run) begin
            if (write_en && write_addr != '0)     r_busy[write_addr]   <= 1'b0;
            if (reserve_en && reserve_addr != '0) r_busy[reserve_addr] <= 1'b1;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] w_ra;
        logic              w_hit;
        w_ra      = '0;
        w_hit     = 1'b0;
        read_data = '0;
        read_busy = '0;
        for (int unsigned i = 0; i < NUM_READ; i++) begin
            w_ra  = read_addr[i*ADDR_W +: ADDR_W];
            w_hit = (BYPASS != 0) && write_en && (write_addr == w_ra);
            if (w_run && w_ra != '0) begin
                if (w_hit) begin
                    read_data[i*DATA_W +: DATA_W] = write_data;
                    read_busy[i]                  = 1'b0;
                end else begin
                    read_data[i*DATA_W +: DATA_W] = r_regs[w_ra];
                    read_busy[i]                  = r_busy[w_ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing and a non-bypassing instance
// share stimulus; table vectors plus reset/clear sequences.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  a0, a1;
    logic [63:0] rdata, nb_rdata;
    logic [1:0]  rbusy, nb_rbusy;
    logic        we, re;
    logic [4:0]  wa, ra;
    logic [31:0] wd;
    logic        rdy, nb_rdy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .read_addr({a1, a0}), .read_data(rdata), .read_busy(rbusy),
        .write_en(we), .write_addr(wa), .write_data(wd),
        .reserve_en(re), .reserve_addr(ra), .ready(rdy)
    );

    regfile_scoreboard #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .read_addr({a1, a0}), .read_data(nb_rdata), .read_busy(nb_rbusy),
        .write_en(we), .write_addr(wa), .write_data(wd),
        .reserve_en(re), .reserve_addr(ra), .ready(nb_rdy)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic [31:0] nd0;
        logic        nb0;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; wa = '0; wd = '0; re = 1'b0; ra = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int start, output int cnt);
        cnt = start;
        while (!(rdy && nb_rdy) && cnt < 200) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd7,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 5'd7,  32'h12345678, 1'b0, 5'd0,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h12345678, 1'b0};
        vecs[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  5'd7,  32'h0,        32'h12345678, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  5'd3,  32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd3,  32'h12345678, 32'h0,        1'b0, 1'b1, 32'h12345678, 1'b0};
        vecs[8]  = '{1'b1, 5'd3,  32'h000000A5, 1'b0, 5'd0,  5'd3,  5'd3,  32'h000000A5, 32'h000000A5, 1'b0, 1'b0, 32'h0,        1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd3,  5'd3,  32'h000000A5, 32'h000000A5, 1'b0, 1'b0, 32'h000000A5, 1'b0};
        vecs[10] = '{1'b1, 5'd9,  32'hCAFE0009, 1'b1, 5'd9,  5'd9,  5'd9,  32'hCAFE0009, 32'hCAFE0009, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd3,  32'hCAFE0009, 32'h000000A5, 1'b1, 1'b0, 32'hCAFE0009, 1'b1};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  32'hCAFE0009, 32'hCAFE0009, 1'b1, 1'b1, 32'hCAFE0009, 1'b1};
        vecs[13] = '{1'b1, 5'd9,  32'h00000011, 1'b0, 5'd0,  5'd9,  5'd5,  32'h00000011, 32'hDEADBEEF, 1'b0, 1'b0, 32'hCAFE0009, 1'b1};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd12, 32'h00000011, 32'h0,        1'b0, 1'b0, 32'h00000011, 1'b0};
        vecs[15] = '{1'b1, 5'd12, 32'h00000077, 1'b0, 5'd0,  5'd12, 5'd12, 32'h00000077, 32'h00000077, 1'b0, 1'b0, 32'h0,        1'b0};
        vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 5'd12, 5'd20, 32'h00000077, 32'h0,        1'b0, 1'b0, 32'h00000077, 1'b0};

        rst = 1'b1; idle(); a0 = 5'd5; a1 = 5'd0;
        step(); step();
        chk("rst_ready", {31'b0, rdy}, 32'd0);
        chk("rst_data", rdata[31:0], 32'h0);
        chk("rst_busy", {30'b0, rbusy}, 32'd0);

        rst = 1'b0;
        wait_ready(0, n);
        chk("clear_len", n, 32'd31);
        chk("nb_ready", {31'b0, nb_rdy}, 32'd1);

        for (int i = 0; i < 17; i++) begin
            we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
            re = vecs[i].re; ra = vecs[i].ra;
            a0 = vecs[i].a0; a1 = vecs[i].a1;
            #1;
            chk($sformatf("v%0d_d0", i), rdata[31:0], vecs[i].d0);
            chk($sformatf("v%0d_d1", i), rdata[63:32], vecs[i].d1);
            chk($sformatf("v%0d_busy", i), {30'b0, rbusy}, {30'b0, vecs[i].b1, vecs[i].b0});
            chk($sformatf("v%0d_nb_d0", i), nb_rdata[31:0], vecs[i].nd0);
            chk($sformatf("v%0d_nb_b0", i), {31'b0, nb_rbusy[0]}, {31'b0, vecs[i].nb0});
            chk($sformatf("v%0d_ready", i), {31'b0, rdy}, 32'd1);
            step();
        end

        // Full reset with reg5 preloaded and reg20 reserved.
        idle(); a0 = 5'd5; a1 = 5'd20;
        rst = 1'b1;
        step();
        chk("rst2_ready", {31'b0, rdy}, 32'd0);
        chk("rst2_d0", rdata[31:0], 32'h0);
        rst = 1'b0;
        wait_ready(0, n);
        chk("clear2_len", n, 32'd31);
        chk("clear2_reg5", rdata[31:0], 32'h0);
        chk("clear2_reg20", rdata[63:32], 32'h0);
        chk("clear2_busy", {30'b0, rbusy}, 32'd0);
        chk("clear2_nb_reg5", nb_rdata[31:0], 32'h0);

        // Reset mid-clear, then traffic to an already-cleared register during CLEAR.
        rst = 1'b1; step(); rst = 1'b0;
        repeat (10) step();
        chk("midclr_ready", {31'b0, rdy}, 32'd0);
        rst = 1'b1; step(); rst = 1'b0;
        repeat (20) step();
        we = 1'b1; wa = 5'd5; wd = 32'hBAD0BAD0; re = 1'b1; ra = 5'd5; a0 = 5'd5; a1 = 5'd5;
        #1;
        chk("inclr_d0", rdata[31:0], 32'h0);
        chk("inclr_busy", {30'b0, rbusy}, 32'd0);
        chk("inclr_ready", {31'b0, rdy}, 32'd0);
        wait_ready(20, n);
        idle();
        #1;
        chk("clear3_len", n, 32'd31);
        chk("clear3_reg5", rdata[31:0], 32'h0);
        chk("clear3_busy", {30'b0, rbusy}, 32'd0);
        chk("clear3_nb_reg5", nb_rdata[31:0], 32'h0);
        chk("clear3_nb_busy", {31'b0, nb_rbusy[0]}, 32'd0);

        we = 1'b1; wa = 5'd5; wd = 32'h00000055;
        step();
        idle();
        #1;
        chk("run_again_d0", rdata[31:0], 32'h00000055);
        chk("run_again_nb_d0", nb_rdata[31:0], 32'h00000055);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
